// File: rtl/hpdcache_mem_arb_pkg.sv
// Shared types for the hpdcache memory read arbiter: source tags, default widths and the
// request record.
package hpdcache_mem_arb_pkg;

  localparam int unsigned MemAddrWidth      = 56;
  localparam int unsigned MemIdWidth        = 6;
  localparam int unsigned MemDataWidth      = 512;
  localparam int unsigned MemMaxOutstanding = 4;

  // Encoding doubles as the MSB of the tagged memory ID.
  typedef enum logic {
    SRC_MISS = 1'b0,
    SRC_UC   = 1'b1
  } mem_src_e;

  typedef struct packed {
    logic [MemAddrWidth-1:0] addr;
    logic [7:0]              len;
    mem_src_e                src;
    logic [MemIdWidth-1:0]   id;
  } mem_req_t;

  function automatic mem_src_e other_src(input mem_src_e src);
    return (src == SRC_MISS) ? SRC_UC : SRC_MISS;
  endfunction

endpackage

// File: rtl/hpdcache_mem_rd_arb_if.sv
// Bundle of every handshake channel around the memory read arbiter. Signal suffixes are
// from the arbiter's point of view; master = arbiter side, slave = cache/memory side.
interface hpdcache_mem_rd_arb_if #(
  parameter int unsigned AddrWidth = 56,
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned DataWidth = 512
) ();

  logic                 miss_req_valid_i;
  logic                 miss_req_ready_o;
  logic [AddrWidth-1:0] miss_req_addr_i;
  logic [7:0]           miss_req_len_i;
  logic [IdWidth-1:0]   miss_req_id_i;

  logic                 uc_req_valid_i;
  logic                 uc_req_ready_o;
  logic [AddrWidth-1:0] uc_req_addr_i;
  logic [7:0]           uc_req_len_i;
  logic [IdWidth-1:0]   uc_req_id_i;

  logic                 mem_req_valid_o;
  logic                 mem_req_ready_i;
  logic [AddrWidth-1:0] mem_req_addr_o;
  logic [7:0]           mem_req_len_o;
  logic [IdWidth:0]     mem_req_id_o;

  logic                 mem_rsp_valid_i;
  logic                 mem_rsp_ready_o;
  logic [IdWidth:0]     mem_rsp_id_i;
  logic [DataWidth-1:0] mem_rsp_data_i;
  logic                 mem_rsp_last_i;

  logic                 miss_rsp_valid_o;
  logic                 miss_rsp_ready_i;
  logic [IdWidth-1:0]   miss_rsp_id_o;
  logic [DataWidth-1:0] miss_rsp_data_o;
  logic                 miss_rsp_last_o;

  logic                 uc_rsp_valid_o;
  logic                 uc_rsp_ready_i;
  logic [IdWidth-1:0]   uc_rsp_id_o;
  logic [DataWidth-1:0] uc_rsp_data_o;
  logic                 uc_rsp_last_o;

  logic                 idle_o;

  modport master (
    input  miss_req_valid_i, miss_req_addr_i, miss_req_len_i, miss_req_id_i,
    output miss_req_ready_o,
    input  uc_req_valid_i, uc_req_addr_i, uc_req_len_i, uc_req_id_i,
    output uc_req_ready_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_id_o,
    input  mem_req_ready_i,
    input  mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_data_i, mem_rsp_last_i,
    output mem_rsp_ready_o,
    output miss_rsp_valid_o, miss_rsp_id_o, miss_rsp_data_o, miss_rsp_last_o,
    input  miss_rsp_ready_i,
    output uc_rsp_valid_o, uc_rsp_id_o, uc_rsp_data_o, uc_rsp_last_o,
    input  uc_rsp_ready_i,
    output idle_o
  );

  modport slave (
    output miss_req_valid_i, miss_req_addr_i, miss_req_len_i, miss_req_id_i,
    input  miss_req_ready_o,
    output uc_req_valid_i, uc_req_addr_i, uc_req_len_i, uc_req_id_i,
    input  uc_req_ready_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_id_o,
    output mem_req_ready_i,
    output mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_data_i, mem_rsp_last_i,
    input  mem_rsp_ready_o,
    input  miss_rsp_valid_o, miss_rsp_id_o, miss_rsp_data_o, miss_rsp_last_o,
    output miss_rsp_ready_i,
    input  uc_rsp_valid_o, uc_rsp_id_o, uc_rsp_data_o, uc_rsp_last_o,
    output uc_rsp_ready_i,
    input  idle_o
  );

endinterface

// File: rtl/hpdcache_mem_req_slice.sv
// Valid/ready register slice: one output entry plus a spill entry, so in_ready_o is a pure
// register output while back-to-back transfers still flow at one per cycle.
module hpdcache_mem_req_slice #(
  parameter type payload_t = logic
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  payload_t in_data_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output payload_t out_data_o
);

  logic     out_valid_q, out_valid_d;
  logic     skid_valid_q, skid_valid_d;
  payload_t out_q, out_d;
  payload_t skid_q, skid_d;
  logic     in_hs, out_free;

  assign in_ready_o  = ~skid_valid_q;
  assign in_hs       = in_valid_i & in_ready_o;
  assign out_free    = ~out_valid_q | out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (out_free) begin
      // Spill entry drains first; in_ready_o is low whenever it is occupied.
      out_valid_d  = skid_valid_q | in_hs;
      out_d        = skid_valid_q ? skid_q : in_data_i;
      skid_valid_d = 1'b0;
    end else if (in_hs) begin
      skid_valid_d = 1'b1;
      skid_d       = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    out_q  <= out_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/hpdcache_mem_rd_arb.sv
// Merges hpdcache miss and uncached reads onto one memory read port, tags IDs with the source
// and demuxes responses back. HPDCACHE_MEM_RD_ARB_OUT_REG_EN registers the request output.
module hpdcache_mem_rd_arb
  import hpdcache_mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth      = MemAddrWidth,
  parameter int unsigned IdWidth        = MemIdWidth,
  parameter int unsigned DataWidth      = MemDataWidth,
  parameter int unsigned MaxOutstanding = MemMaxOutstanding
) (
  input logic                   clk_i,
  input logic                   rst_i,
  hpdcache_mem_rd_arb_if.master bus_io
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [IdWidth:0]     id;
  } req_t;

  req_t     [1:0]               req_pld;
  logic     [1:0]               req_valid, elig, inc, dec;
  logic     [1:0][CntWidth-1:0] cnt_q, cnt_d;
  mem_src_e                     rr_q, rr_d, lock_src_q, lock_src_d, gnt_src;
  logic                         lock_q, lock_d;
  logic                         gnt_valid, up_ready, src_hs;
  req_t                         gnt_pld;

  // ---------------------------------------------------------------------------------------------
  // Request arbitration
  // ---------------------------------------------------------------------------------------------
  assign req_valid  = {bus_io.uc_req_valid_i, bus_io.miss_req_valid_i};
  assign req_pld[0] = '{addr: bus_io.miss_req_addr_i, len: bus_io.miss_req_len_i,
                        id: {SRC_MISS, bus_io.miss_req_id_i}};
  assign req_pld[1] = '{addr: bus_io.uc_req_addr_i, len: bus_io.uc_req_len_i,
                        id: {SRC_UC, bus_io.uc_req_id_i}};

  for (genvar s = 0; s < 2; s++) begin : gen_elig
    assign elig[s] = req_valid[s] & (cnt_q[s] < CntMax);
  end

  // A pending grant is held until it is taken, whatever the other source does meanwhile.
  always_comb begin
    if (lock_q) begin
      gnt_src = lock_src_q;
    end else if (elig == 2'b01) begin
      gnt_src = SRC_MISS;
    end else if (elig == 2'b10) begin
      gnt_src = SRC_UC;
    end else begin
      gnt_src = rr_q;
    end
  end

  assign gnt_valid = elig[gnt_src];
  assign gnt_pld   = req_pld[gnt_src];
  assign src_hs    = gnt_valid & up_ready;

  assign bus_io.miss_req_ready_o = src_hs & (gnt_src == SRC_MISS);
  assign bus_io.uc_req_ready_o   = src_hs & (gnt_src == SRC_UC);

  always_comb begin
    rr_d       = rr_q;
    lock_d     = 1'b0;
    lock_src_d = lock_src_q;
    if (src_hs) begin
      rr_d = other_src(gnt_src);
    end else if (gnt_valid) begin
      lock_d     = 1'b1;
      lock_src_d = gnt_src;
    end
  end

`ifdef HPDCACHE_MEM_RD_ARB_OUT_REG_EN
  req_t slice_data;
  logic slice_valid;

  hpdcache_mem_req_slice #(
    .payload_t (req_t)
  ) u_req_slice (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (gnt_valid),
    .in_ready_o  (up_ready),
    .in_data_i   (gnt_pld),
    .out_valid_o (slice_valid),
    .out_ready_i (bus_io.mem_req_ready_i),
    .out_data_o  (slice_data)
  );

  assign bus_io.mem_req_valid_o = slice_valid;
  assign bus_io.mem_req_addr_o  = slice_data.addr;
  assign bus_io.mem_req_len_o   = slice_data.len;
  assign bus_io.mem_req_id_o    = slice_data.id;
`else
  assign up_ready               = bus_io.mem_req_ready_i;
  assign bus_io.mem_req_valid_o = gnt_valid;
  assign bus_io.mem_req_addr_o  = gnt_pld.addr;
  assign bus_io.mem_req_len_o   = gnt_pld.len;
  assign bus_io.mem_req_id_o    = gnt_pld.id;
`endif

  // ---------------------------------------------------------------------------------------------
  // Response demux
  // ---------------------------------------------------------------------------------------------
  logic                 rsp_sel, rsp_done;
  logic [DataWidth-1:0] rsp_data;

  assign rsp_sel  = bus_io.mem_rsp_id_i[IdWidth];
  assign rsp_data = bus_io.mem_rsp_data_i;

  assign bus_io.mem_rsp_ready_o  = rsp_sel ? bus_io.uc_rsp_ready_i : bus_io.miss_rsp_ready_i;
  assign bus_io.miss_rsp_valid_o = bus_io.mem_rsp_valid_i & ~rsp_sel;
  assign bus_io.uc_rsp_valid_o   = bus_io.mem_rsp_valid_i & rsp_sel;
  assign bus_io.miss_rsp_id_o    = bus_io.mem_rsp_id_i[IdWidth-1:0];
  assign bus_io.uc_rsp_id_o      = bus_io.mem_rsp_id_i[IdWidth-1:0];
  assign bus_io.miss_rsp_data_o  = rsp_data;
  assign bus_io.uc_rsp_data_o    = rsp_data;
  assign bus_io.miss_rsp_last_o  = bus_io.mem_rsp_last_i;
  assign bus_io.uc_rsp_last_o    = bus_io.mem_rsp_last_i;

  assign rsp_done = bus_io.mem_rsp_valid_i & bus_io.mem_rsp_ready_o & bus_io.mem_rsp_last_i;

  // ---------------------------------------------------------------------------------------------
  // Outstanding counters
  // ---------------------------------------------------------------------------------------------
  assign inc = {src_hs & (gnt_src == SRC_UC), src_hs & (gnt_src == SRC_MISS)};

  // A stray last beat on an empty counter is dropped rather than wrapping it.
  assign dec = {rsp_done & rsp_sel & (cnt_q[1] != '0), rsp_done & ~rsp_sel & (cnt_q[0] != '0)};

  always_comb begin
    cnt_d = cnt_q;
    for (int s = 0; s < 2; s++) begin
      if (inc[s] && !dec[s]) begin
        cnt_d[s] = cnt_q[s] + CntWidth'(1);
      end else if (dec[s] && !inc[s]) begin
        cnt_d[s] = cnt_q[s] - CntWidth'(1);
      end
    end
  end

  assign bus_io.idle_o = (cnt_q[0] == '0) & (cnt_q[1] == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      rr_q       <= SRC_MISS;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_MISS;
    end else begin
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end

  rsp_last_underflow_a: assert property (
    @(posedge clk_i) disable iff (rst_i) !(rsp_done && (cnt_q[rsp_sel] == '0))
  );

endmodule

// File: tb/tb_hpdcache_mem_rd_arb.sv
// Directed bench for hpdcache_mem_rd_arb: a per-cycle reference model of the arbitration and
// demux rules plus hand-computed spot checks.
module tb_hpdcache_mem_rd_arb;
  import hpdcache_mem_arb_pkg::*;

  localparam int unsigned AddrW  = 56;
  localparam int unsigned IdW    = 6;
  localparam int unsigned DataW  = 512;
  localparam int          MaxOut = 4;

  typedef logic [511:0] w_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hpdcache_mem_rd_arb_if #(.AddrWidth(AddrW), .IdWidth(IdW), .DataWidth(DataW)) bus ();

  hpdcache_mem_rd_arb #(
    .AddrWidth      (AddrW),
    .IdWidth        (IdW),
    .DataWidth      (DataW),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.miss_req_valid_i = 1'b0; bus.miss_req_addr_i = '0; bus.miss_req_len_i = '0;
    bus.miss_req_id_i    = '0;
    bus.uc_req_valid_i   = 1'b0; bus.uc_req_addr_i = '0; bus.uc_req_len_i = '0;
    bus.uc_req_id_i      = '0;
    bus.mem_req_ready_i  = 1'b0;
    bus.mem_rsp_valid_i  = 1'b0; bus.mem_rsp_id_i = '0; bus.mem_rsp_data_i = '0;
    bus.mem_rsp_last_i   = 1'b0;
    bus.miss_rsp_ready_i = 1'b0; bus.uc_rsp_ready_i = 1'b0;
  endtask

  task automatic rst_pulse();
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

`ifndef HPDCACHE_MEM_RD_ARB_OUT_REG_EN
  // Reference model: per-source in-flight counts, preferred source and the held grant.
  int m_cnt[2] = '{0, 0};
  int m_pref   = 0;
  int m_held   = -1;
  int e_inc[2] = '{0, 0};
  int e_dec[2] = '{0, 0};
  int e_g      = 0;
  bit e_v      = 1'b0;
  bit e_hs     = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin : cmp
      bit       el[2];
      int       g;
      bit       v, sel, rrdy;
      logic [6:0] eid;
      el[0] = bus.miss_req_valid_i && (m_cnt[0] < MaxOut);
      el[1] = bus.uc_req_valid_i && (m_cnt[1] < MaxOut);
      if (m_held >= 0)         g = m_held;
      else if (el[0] && el[1]) g = m_pref;
      else if (el[0])          g = 0;
      else                     g = 1;
      v = el[g];
      chk("model mem_req_valid", w_t'(bus.mem_req_valid_o), w_t'(v));
      if (v) begin
        eid = (g == 0) ? {1'b0, bus.miss_req_id_i} : {1'b1, bus.uc_req_id_i};
        chk("model mem_req_id", w_t'(bus.mem_req_id_o), w_t'(eid));
        chk("model mem_req_addr", w_t'(bus.mem_req_addr_o),
            w_t'((g == 0) ? bus.miss_req_addr_i : bus.uc_req_addr_i));
        chk("model mem_req_len", w_t'(bus.mem_req_len_o),
            w_t'((g == 0) ? bus.miss_req_len_i : bus.uc_req_len_i));
      end
      chk("model miss_req_ready", w_t'(bus.miss_req_ready_o),
          w_t'(v && g == 0 && bus.mem_req_ready_i));
      chk("model uc_req_ready", w_t'(bus.uc_req_ready_o),
          w_t'(v && g == 1 && bus.mem_req_ready_i));
      sel  = bus.mem_rsp_id_i[6];
      rrdy = sel ? bus.uc_rsp_ready_i : bus.miss_rsp_ready_i;
      chk("model miss_rsp_valid", w_t'(bus.miss_rsp_valid_o), w_t'(bus.mem_rsp_valid_i && !sel));
      chk("model uc_rsp_valid", w_t'(bus.uc_rsp_valid_o), w_t'(bus.mem_rsp_valid_i && sel));
      chk("model mem_rsp_ready", w_t'(bus.mem_rsp_ready_o), w_t'(rrdy));
      chk("model miss_rsp_id", w_t'(bus.miss_rsp_id_o), w_t'(bus.mem_rsp_id_i[5:0]));
      chk("model uc_rsp_id", w_t'(bus.uc_rsp_id_o), w_t'(bus.mem_rsp_id_i[5:0]));
      chk("model miss_rsp_data", bus.miss_rsp_data_o, bus.mem_rsp_data_i);
      chk("model uc_rsp_data", bus.uc_rsp_data_o, bus.mem_rsp_data_i);
      chk("model miss_rsp_last", w_t'(bus.miss_rsp_last_o), w_t'(bus.mem_rsp_last_i));
      chk("model uc_rsp_last", w_t'(bus.uc_rsp_last_o), w_t'(bus.mem_rsp_last_i));
      chk("model idle", w_t'(bus.idle_o), w_t'(m_cnt[0] == 0 && m_cnt[1] == 0));
      for (int s = 0; s < 2; s++) begin
        e_inc[s] <= (v && bus.mem_req_ready_i && g == s) ? 1 : 0;
        e_dec[s] <= (bus.mem_rsp_valid_i && rrdy && bus.mem_rsp_last_i && int'(sel) == s &&
                     m_cnt[s] > 0) ? 1 : 0;
      end
      e_g  <= g;
      e_v  <= v;
      e_hs <= v && bus.mem_req_ready_i;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_cnt[0] <= 0;
      m_cnt[1] <= 0;
      m_pref   <= 0;
      m_held   <= -1;
    end else begin
      for (int s = 0; s < 2; s++) m_cnt[s] <= m_cnt[s] + e_inc[s] - e_dec[s];
      if (e_hs) begin
        m_pref <= 1 - e_g;
        m_held <= -1;
      end else if (e_v) begin
        m_held <= e_g;
      end else begin
        m_held <= -1;
      end
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_req_t   uc_t3;
    logic [6:0] exp_ids [4];
    int         beat;
    int         cyc;
    exp_ids = '{7'h01, 7'h42, 7'h01, 7'h42};
    uc_t3   = '{addr: 56'h4440, len: 8'd1, src: SRC_UC, id: 6'd5};

    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset mem_req_valid", w_t'(bus.mem_req_valid_o), w_t'(0));
    chk("reset idle", w_t'(bus.idle_o), w_t'(1));
    chk("reset miss_rsp_valid", w_t'(bus.miss_rsp_valid_o), w_t'(0));
    chk("reset uc_rsp_valid", w_t'(bus.uc_rsp_valid_o), w_t'(0));

`ifdef HPDCACHE_MEM_RD_ARB_OUT_REG_EN
    tick();
    rst = 1'b0;
    bus.miss_req_valid_i = 1'b1; bus.miss_req_addr_i = 56'h1000; bus.miss_req_id_i = 6'd3;
    bus.mem_req_ready_i  = 1'b1;
    @(negedge clk);
    chk("reg src handshake", w_t'(bus.miss_req_ready_o), w_t'(1));
    chk("reg mem_req_valid same cycle", w_t'(bus.mem_req_valid_o), w_t'(0));
    tick();
    bus.miss_req_valid_i = 1'b0;
    @(negedge clk);
    chk("reg mem_req_valid next cycle", w_t'(bus.mem_req_valid_o), w_t'(1));
    chk("reg mem_req_id", w_t'(bus.mem_req_id_o), w_t'(7'h03));
    chk("reg mem_req_addr", w_t'(bus.mem_req_addr_o), w_t'(56'h1000));
    chk("reg idle", w_t'(bus.idle_o), w_t'(0));
    tick();
    @(negedge clk);
    chk("reg mem_req_valid drained", w_t'(bus.mem_req_valid_o), w_t'(0));
`else
    // Single miss request, then its one-beat response.
    tick();
    rst = 1'b0;
    bus.miss_req_valid_i = 1'b1; bus.miss_req_addr_i = 56'h1000; bus.miss_req_id_i = 6'd3;
    bus.mem_req_ready_i  = 1'b1;
    @(negedge clk);
    chk("t1 mem_req_id", w_t'(bus.mem_req_id_o), w_t'(7'h03));
    chk("t1 mem_req_addr", w_t'(bus.mem_req_addr_o), w_t'(56'h1000));
    chk("t1 miss_req_ready", w_t'(bus.miss_req_ready_o), w_t'(1));
    chk("t1 uc_req_ready", w_t'(bus.uc_req_ready_o), w_t'(0));
    tick();
    bus.miss_req_valid_i = 1'b0;
    @(negedge clk);
    chk("t1 idle after req", w_t'(bus.idle_o), w_t'(0));
    tick();
    bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_id_i = 7'h03; bus.mem_rsp_last_i = 1'b1;
    bus.mem_rsp_data_i  = w_t'(64'hABCD_0123); bus.miss_rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("t1 miss_rsp_valid", w_t'(bus.miss_rsp_valid_o), w_t'(1));
    chk("t1 uc_rsp_valid", w_t'(bus.uc_rsp_valid_o), w_t'(0));
    chk("t1 miss_rsp_id", w_t'(bus.miss_rsp_id_o), w_t'(6'h03));
    tick();
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("t1 idle after rsp", w_t'(bus.idle_o), w_t'(1));

    // Both sources valid every cycle: strict alternation starting with miss.
    rst_pulse();
    bus.miss_req_valid_i = 1'b1; bus.miss_req_addr_i = 56'h2000; bus.miss_req_id_i = 6'd1;
    bus.uc_req_valid_i   = 1'b1; bus.uc_req_addr_i = 56'h3000; bus.uc_req_id_i = 6'd2;
    bus.uc_req_len_i     = 8'd3; bus.mem_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t2 grant %0d id", i), w_t'(bus.mem_req_id_o), w_t'(exp_ids[i]));
      tick();
    end
    bus.miss_req_valid_i = 1'b0; bus.uc_req_valid_i = 1'b0;
    @(negedge clk);
    chk("t2 idle busy", w_t'(bus.idle_o), w_t'(0));
    rst_pulse();
    @(negedge clk);
    chk("t2 idle after mid reset", w_t'(bus.idle_o), w_t'(1));

    // Held uc grant survives three stalled cycles and a newly valid miss.
    rst_pulse();
    bus.uc_req_valid_i = 1'b1; bus.uc_req_addr_i = uc_t3.addr; bus.uc_req_len_i = uc_t3.len;
    bus.uc_req_id_i    = uc_t3.id; bus.mem_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3 stall %0d id", i), w_t'(bus.mem_req_id_o), w_t'({uc_t3.src, uc_t3.id}));
      chk($sformatf("t3 stall %0d addr", i), w_t'(bus.mem_req_addr_o), w_t'(56'h4440));
      chk($sformatf("t3 stall %0d miss_ready", i), w_t'(bus.miss_req_ready_o), w_t'(0));
      tick();
      bus.miss_req_valid_i = 1'b1; bus.miss_req_addr_i = 56'h5000; bus.miss_req_id_i = 6'd3;
    end
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("t3 uc handshake", w_t'(bus.uc_req_ready_o), w_t'(1));
    chk("t3 miss waits", w_t'(bus.miss_req_ready_o), w_t'(0));
    tick();
    bus.uc_req_valid_i = 1'b0;
    @(negedge clk);
    chk("t3 miss after uc", w_t'(bus.miss_req_ready_o), w_t'(1));
    chk("t3 miss id", w_t'(bus.mem_req_id_o), w_t'(7'h03));
    tick();
    bus.miss_req_valid_i = 1'b0;

    // Outstanding limit on the miss source.
    rst_pulse();
    bus.miss_req_valid_i = 1'b1; bus.miss_req_addr_i = 56'h6000; bus.miss_req_id_i = 6'd2;
    bus.mem_req_ready_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t4 req %0d ready", i), w_t'(bus.miss_req_ready_o), w_t'(1));
      tick();
    end
    @(negedge clk);
    chk("t4 fifth blocked", w_t'(bus.miss_req_ready_o), w_t'(0));
    chk("t4 fifth no mem valid", w_t'(bus.mem_req_valid_o), w_t'(0));
    tick();
    bus.mem_rsp_valid_i  = 1'b1; bus.mem_rsp_id_i = 7'h02; bus.mem_rsp_last_i = 1'b1;
    bus.miss_rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("t4 still blocked during rsp", w_t'(bus.miss_req_ready_o), w_t'(0));
    tick();
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("t4 re-enabled", w_t'(bus.miss_req_ready_o), w_t'(1));
    tick();
    bus.miss_req_valid_i = 1'b0;

    // Four-beat uc response with a toggling sink ready.
    rst_pulse();
    bus.uc_req_valid_i = 1'b1; bus.uc_req_id_i = 6'd5; bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("t5 uc req", w_t'(bus.uc_req_ready_o), w_t'(1));
    tick();
    bus.uc_req_valid_i   = 1'b0;
    bus.mem_rsp_valid_i  = 1'b1; bus.mem_rsp_id_i = 7'h45; bus.miss_rsp_ready_i = 1'b1;
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 20) begin
      bus.uc_rsp_ready_i = cyc[0];
      bus.mem_rsp_last_i = (beat == 3);
      bus.mem_rsp_data_i = w_t'(32'hBE00 + beat);
      @(negedge clk);
      chk($sformatf("t5 c%0d uc_valid", cyc), w_t'(bus.uc_rsp_valid_o), w_t'(1));
      chk($sformatf("t5 c%0d miss_valid", cyc), w_t'(bus.miss_rsp_valid_o), w_t'(0));
      chk($sformatf("t5 c%0d uc_id", cyc), w_t'(bus.uc_rsp_id_o), w_t'(6'h05));
      chk($sformatf("t5 c%0d mem_ready", cyc), w_t'(bus.mem_rsp_ready_o), w_t'(cyc[0]));
      chk($sformatf("t5 c%0d idle", cyc), w_t'(bus.idle_o), w_t'(0));
      if (cyc[0]) beat++;
      tick();
      cyc++;
    end
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_last_i  = 1'b0;
    @(negedge clk);
    chk("t5 beats delivered", w_t'(beat), w_t'(4));
    chk("t5 idle after last", w_t'(bus.idle_o), w_t'(1));
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
